// File: rtl/pipe_ctrl_gen_pkg.sv
// Shared constants for the pipeline controller: FSM encodings, mtvec modes,
// CSR cause width and the trap-vector address helper.
package pipe_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_TRAP = 2'd1;
    localparam state_t ST_RET  = 2'd2;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

    // mcause image is {interrupt, code}
    localparam int CAUSE_W = 6;
    localparam int CODE_W  = CAUSE_W - 1;

    // Widest address the helper handles; callers cast to their own XLEN.
    localparam int ADDR_MAX_W = 64;

    // Vectored interrupts land at base + 4*id; everything else lands on base.
    function automatic logic [ADDR_MAX_W-1:0] trap_vector(
        input logic [ADDR_MAX_W-1:0] base_addr,
        input logic [ADDR_MAX_W-1:0] irq_num,
        input logic                  vec_irq
    );
        return vec_irq ? (base_addr + (irq_num << 2)) : base_addr;
    endfunction

endpackage

// File: rtl/pipe_ctrl_gen_if.sv
// Control bundle between the pipeline datapath (master) and the pipeline
// controller (slave): hazard/trap requests in, redirect and per-stage
// flush/stall out.
interface pipe_ctrl_gen_if
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE = 5,
    parameter int XLEN   = 32,
    parameter int IRQ_W  = 5
) ();

    logic [NSTAGE-1:0]  stall_req;
    logic               branch_taken;
    logic               jump_taken;
    logic [XLEN-1:0]    branch_target_addr;
    logic [XLEN-1:0]    jump_target_addr;
    logic               fence;
    logic [XLEN-1:0]    pc_if;
    logic               exc_taken_wb;
    logic [CAUSE_W-1:0] exc_cause_wb;
    logic [XLEN-1:0]    exc_pc_wb;
    logic               mret_wb;
    logic               irq_pending;
    logic [IRQ_W-1:0]   irq_id;
    logic [XLEN-1:0]    mtvec;
    logic [XLEN-1:0]    mepc;

    logic               set_pc_valid;
    logic [XLEN-1:0]    set_pc;
    logic [NSTAGE-1:0]  flush;
    logic [NSTAGE-1:0]  stall;
    logic               csr_save;
    logic [CAUSE_W-1:0] csr_cause;
    logic [XLEN-1:0]    csr_epc;
    logic               csr_mret;
    logic               irq_taken_wb;

    modport master (
        output stall_req, branch_taken, jump_taken, branch_target_addr,
               jump_target_addr, fence, pc_if, exc_taken_wb, exc_cause_wb,
               exc_pc_wb, mret_wb, irq_pending, irq_id, mtvec, mepc,
        input  set_pc_valid, set_pc, flush, stall, csr_save, csr_cause,
               csr_epc, csr_mret, irq_taken_wb
    );

    modport slave (
        input  stall_req, branch_taken, jump_taken, branch_target_addr,
               jump_target_addr, fence, pc_if, exc_taken_wb, exc_cause_wb,
               exc_pc_wb, mret_wb, irq_pending, irq_id, mtvec, mepc,
        output set_pc_valid, set_pc, flush, stall, csr_save, csr_cause,
               csr_epc, csr_mret, irq_taken_wb
    );

endinterface

// File: rtl/pipe_ctrl_gen_stall_chain.sv
// Back-pressure chain: a stage holds if it or any later stage asks to hold,
// and a bubble is injected into the first stage past the held region.
module pipe_stall_chain
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE = 5
) (
    input  logic [NSTAGE-1:0] stall_req,
    output logic [NSTAGE-1:0] stall_chain,
    output logic [NSTAGE-1:0] bubble
);

    for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
        // Each stage sees the OR of its own request and every downstream one.
        assign stall_chain[i] = |stall_req[NSTAGE-1:i];

        if (i == 0) begin : g_first
            assign bubble[i] = 1'b0;
        end else begin : g_rest
            assign bubble[i] = stall_chain[i-1] & ~stall_chain[i];
        end
    end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline controller for the in-order core: per-stage flush/stall,
// branch/fence redirect, and the trap/return sequencer that steers fetch
// to mtvec or mepc one cycle after the event retires at W.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | normal flow; hazards, redirects and trap/mret detection
//   TRAP    | pipeline drained by trap; redirect fetch to latched vector
//   RET     | pipeline drained by mret; redirect fetch to latched mepc
module pipe_ctrl_gen
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE   = 5,
    parameter int XLEN     = 32,
    parameter int BR_STAGE = 2,
    parameter int IRQ_W    = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    pipe_ctrl_gen_if.slave bus
);

    // Stages upstream of the branch resolver hold wrong-path instructions.
    localparam logic [NSTAGE-1:0] BR_MASK = NSTAGE'((1 << BR_STAGE) - 1);
    localparam logic [NSTAGE-1:0] F_MASK  = NSTAGE'(1);

    state_t            state_q;
    state_t            state_d;
    logic [XLEN-1:0]   target_q;
    logic [XLEN-1:0]   target_d;

    logic [NSTAGE-1:0] stall_chain;
    logic [NSTAGE-1:0] bubble;
    logic [NSTAGE-1:0] flush_v;

    logic              in_idle;
    logic              exc_take;
    logic              irq_take;
    logic              trap_take;
    logic              ret_take;
    logic              redir_req;
    logic              br_accept;
    logic              fence_accept;
    logic              vec_irq;
    logic [XLEN-1:0]   br_addr;
    logic [XLEN-1:0]   mtvec_base;
    logic [XLEN-1:0]   trap_addr;

    pipe_stall_chain #(
        .NSTAGE (NSTAGE)
    ) u_stall_chain (
        .stall_req   (bus.stall_req),
        .stall_chain (stall_chain),
        .bubble      (bubble)
    );

    // Event qualification; exception beats interrupt, trap beats mret,
    // and both beat any younger redirect.
    always_comb begin
        in_idle      = (state_q == ST_IDLE);
        exc_take     = in_idle & bus.exc_taken_wb;
        irq_take     = in_idle & bus.irq_pending & ~bus.exc_taken_wb
                       & ~stall_chain[NSTAGE-1] & ~bus.mret_wb;
        trap_take    = exc_take | irq_take;
        ret_take     = in_idle & bus.mret_wb & ~bus.exc_taken_wb;
        redir_req    = bus.branch_taken | bus.jump_taken;
        br_accept    = in_idle & redir_req & ~stall_chain[BR_STAGE]
                       & ~trap_take & ~bus.mret_wb;
        fence_accept = in_idle & bus.fence & ~redir_req & ~trap_take
                       & ~bus.mret_wb & ~stall_chain[1];
        br_addr      = bus.jump_taken ? bus.jump_target_addr
                                      : bus.branch_target_addr;
    end

    // Trap vector: mode bits are masked off the base; only a vectored
    // interrupt adds the 4*id offset, exceptions always use the base.
    always_comb begin
        mtvec_base = {bus.mtvec[XLEN-1:2], 2'b00};
        vec_irq    = (bus.mtvec[1:0] == MTVEC_VECTORED) & irq_take;
        trap_addr  = XLEN'(trap_vector(ADDR_MAX_W'(mtvec_base),
                                       ADDR_MAX_W'(bus.irq_id),
                                       vec_irq));
    end

    // Next-state and redirect target capture.
    always_comb begin
        state_d  = ST_IDLE;
        target_d = target_q;
        case (state_q)
            ST_IDLE: begin
                if (trap_take) begin
                    state_d  = ST_TRAP;
                    target_d = trap_addr;
                end else if (ret_take) begin
                    state_d  = ST_RET;
                    target_d = bus.mepc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; flush always overrides stall in the same stage.
    always_comb begin
        flush_v          = '0;
        bus.set_pc_valid = 1'b0;
        bus.set_pc       = '0;
        bus.flush        = '0;
        bus.stall        = '0;
        bus.csr_save     = 1'b0;
        bus.csr_cause    = '0;
        bus.csr_epc      = '0;
        bus.csr_mret     = 1'b0;
        bus.irq_taken_wb = 1'b0;

        if (!in_idle) begin
            // Pipeline is already empty; just restart fetch at the target.
            bus.set_pc_valid = 1'b1;
            bus.set_pc       = target_q;
            bus.flush        = F_MASK;
        end else begin
            flush_v = bubble;
            if (trap_take || ret_take) begin
                flush_v = '1;
            end else if (br_accept) begin
                flush_v          = bubble | BR_MASK;
                bus.set_pc_valid = 1'b1;
                bus.set_pc       = br_addr;
            end else if (fence_accept) begin
                flush_v          = bubble | F_MASK;
                bus.set_pc_valid = 1'b1;
                bus.set_pc       = bus.pc_if;
            end

            bus.flush = flush_v;
            bus.stall = stall_chain & ~flush_v;

            if (trap_take) begin
                bus.csr_save  = 1'b1;
                bus.csr_epc   = bus.exc_pc_wb;
                bus.csr_cause = exc_take
                                ? (bus.exc_cause_wb & {1'b0, {CODE_W{1'b1}}})
                                : {1'b1, CODE_W'(bus.irq_id)};
            end
            bus.csr_mret     = ret_take;
            bus.irq_taken_wb = irq_take;
        end
    end

    // State and latched redirect target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench for pipe_ctrl_gen: hazards, redirects, trap/mret sequencing.
module tb_pipe_ctrl_gen;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipe_ctrl_gen_if #(.NSTAGE(5), .XLEN(32), .IRQ_W(5)) bus ();

    pipe_ctrl_gen #(
        .NSTAGE   (5),
        .XLEN     (32),
        .BR_STAGE (2),
        .IRQ_W    (5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.stall_req          = '0;
        bus.branch_taken       = 1'b0;
        bus.jump_taken         = 1'b0;
        bus.branch_target_addr = '0;
        bus.jump_target_addr   = '0;
        bus.fence              = 1'b0;
        bus.pc_if              = '0;
        bus.exc_taken_wb       = 1'b0;
        bus.exc_cause_wb       = '0;
        bus.exc_pc_wb          = '0;
        bus.mret_wb            = 1'b0;
        bus.irq_pending        = 1'b0;
        bus.irq_id             = '0;
        bus.mtvec              = '0;
        bus.mepc               = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        settle();
        check_val("rst_valid",   64'(bus.set_pc_valid), 64'h0);
        check_val("rst_flush",   64'(bus.flush),        64'h0);
        check_val("rst_stall",   64'(bus.stall),        64'h0);
        check_val("rst_save",    64'(bus.csr_save),     64'h0);
        next_cycle();
        reset_n = 1'b1;

        // M busy: hold F..M, bubble into W
        bus.stall_req = 5'b01000;
        settle();
        check_val("m_busy_stall", 64'(bus.stall), 64'h0F);
        check_val("m_busy_flush", 64'(bus.flush), 64'h10);
        next_cycle();
        bus.stall_req = '0;
        settle();
        check_val("release_stall", 64'(bus.stall), 64'h0);
        check_val("release_flush", 64'(bus.flush), 64'h0);

        // branch redirect
        next_cycle();
        bus.branch_taken       = 1'b1;
        bus.branch_target_addr = 32'h100;
        settle();
        check_val("br_valid", 64'(bus.set_pc_valid), 64'h1);
        check_val("br_pc",    64'(bus.set_pc),       64'h100);
        check_val("br_flush", 64'(bus.flush),        64'h03);
        check_val("br_stall", 64'(bus.stall),        64'h0);

        // branch while EX held -> dropped
        next_cycle();
        bus.stall_req = 5'b00100;
        settle();
        check_val("br_hold_valid", 64'(bus.set_pc_valid), 64'h0);
        check_val("br_hold_pc",    64'(bus.set_pc),       64'h0);
        check_val("br_hold_stall", 64'(bus.stall),        64'h07);
        check_val("br_hold_flush", 64'(bus.flush),        64'h08);

        // jump wins over branch
        next_cycle();
        bus.stall_req        = '0;
        bus.jump_taken       = 1'b1;
        bus.jump_target_addr = 32'h300;
        settle();
        check_val("jmp_pc", 64'(bus.set_pc), 64'h300);

        // synchronous exception, direct mtvec
        next_cycle();
        clear_inputs();
        bus.mtvec        = 32'h1000;
        bus.exc_taken_wb = 1'b1;
        bus.exc_cause_wb = 6'h02;
        bus.exc_pc_wb    = 32'h80;
        settle();
        check_val("exc_flush", 64'(bus.flush),        64'h1F);
        check_val("exc_save",  64'(bus.csr_save),     64'h1);
        check_val("exc_cause", 64'(bus.csr_cause),    64'h02);
        check_val("exc_epc",   64'(bus.csr_epc),      64'h80);
        check_val("exc_valid", 64'(bus.set_pc_valid), 64'h0);
        next_cycle();
        bus.stall_req = 5'b11111;
        settle();
        check_val("trap_valid", 64'(bus.set_pc_valid), 64'h1);
        check_val("trap_pc",    64'(bus.set_pc),       64'h1000);
        check_val("trap_flush", 64'(bus.flush),        64'h01);
        check_val("trap_stall", 64'(bus.stall),        64'h0);
        check_val("trap_ignore_save", 64'(bus.csr_save), 64'h0);
        next_cycle();
        clear_inputs();
        settle();
        check_val("trap_done_valid", 64'(bus.set_pc_valid), 64'h0);

        // vectored interrupt, first blocked by W stall
        bus.mtvec       = 32'h1001;
        bus.irq_pending = 1'b1;
        bus.irq_id      = 5'd7;
        bus.exc_pc_wb   = 32'h84;
        bus.stall_req   = 5'b10000;
        settle();
        check_val("irq_blk_taken", 64'(bus.irq_taken_wb), 64'h0);
        check_val("irq_blk_save",  64'(bus.csr_save),     64'h0);
        check_val("irq_blk_stall", 64'(bus.stall),        64'h1F);
        next_cycle();
        bus.stall_req = '0;
        settle();
        check_val("irq_taken", 64'(bus.irq_taken_wb), 64'h1);
        check_val("irq_cause", 64'(bus.csr_cause),    64'h27);
        check_val("irq_epc",   64'(bus.csr_epc),      64'h84);
        check_val("irq_flush", 64'(bus.flush),        64'h1F);
        next_cycle();
        bus.irq_pending = 1'b0;
        settle();
        check_val("irq_vec_valid", 64'(bus.set_pc_valid), 64'h1);
        check_val("irq_vec_pc",    64'(bus.set_pc),       64'h101C);

        // exception + irq + branch together; vectored exception uses base
        next_cycle();
        bus.exc_taken_wb       = 1'b1;
        bus.exc_cause_wb       = 6'h25;
        bus.exc_pc_wb          = 32'h90;
        bus.irq_pending        = 1'b1;
        bus.irq_id             = 5'd7;
        bus.branch_taken       = 1'b1;
        bus.branch_target_addr = 32'h100;
        settle();
        check_val("mix_cause", 64'(bus.csr_cause),    64'h05);
        check_val("mix_irq",   64'(bus.irq_taken_wb), 64'h0);
        check_val("mix_valid", 64'(bus.set_pc_valid), 64'h0);
        check_val("mix_flush", 64'(bus.flush),        64'h1F);
        next_cycle();
        clear_inputs();
        settle();
        check_val("mix_vec_pc", 64'(bus.set_pc), 64'h1000);

        // mret
        next_cycle();
        bus.mret_wb = 1'b1;
        bus.mepc    = 32'h200;
        settle();
        check_val("mret_strobe", 64'(bus.csr_mret),     64'h1);
        check_val("mret_flush",  64'(bus.flush),        64'h1F);
        check_val("mret_valid",  64'(bus.set_pc_valid), 64'h0);
        check_val("mret_save",   64'(bus.csr_save),     64'h0);
        next_cycle();
        clear_inputs();
        settle();
        check_val("ret_valid", 64'(bus.set_pc_valid), 64'h1);
        check_val("ret_pc",    64'(bus.set_pc),       64'h200);
        check_val("ret_mret",  64'(bus.csr_mret),     64'h0);

        // reset during the TRAP cycle
        next_cycle();
        bus.mtvec        = 32'h1000;
        bus.exc_taken_wb = 1'b1;
        bus.exc_cause_wb = 6'h01;
        bus.exc_pc_wb    = 32'hA0;
        next_cycle();
        clear_inputs();
        reset_n = 1'b0;
        settle();
        check_val("rst_trap_valid", 64'(bus.set_pc_valid), 64'h0);
        next_cycle();
        reset_n = 1'b1;
        settle();
        check_val("post_rst_valid", 64'(bus.set_pc_valid), 64'h0);
        next_cycle();
        settle();
        check_val("post_rst_valid2", 64'(bus.set_pc_valid), 64'h0);
        check_val("post_rst_pc",     64'(bus.set_pc),       64'h0);

        // fence refetch, then fence blocked by decode hold
        bus.fence = 1'b1;
        bus.pc_if = 32'h40;
        settle();
        check_val("fence_valid", 64'(bus.set_pc_valid), 64'h1);
        check_val("fence_pc",    64'(bus.set_pc),       64'h40);
        check_val("fence_flush", 64'(bus.flush),        64'h01);
        next_cycle();
        bus.stall_req = 5'b00010;
        settle();
        check_val("fence_hold_valid", 64'(bus.set_pc_valid), 64'h0);
        check_val("fence_hold_stall", 64'(bus.stall),        64'h03);
        check_val("fence_hold_flush", 64'(bus.flush),        64'h04);

        next_cycle();
        clear_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_gen.md
Name: pipe_ctrl_gen

Overview:
Parametrised pipeline controller for the in-order RISC-V core with NSTAGE stages (index 0 = F … NSTAGE-1 = W).
- Generates per-stage flush/stall vectors from branch/jump, fence, per-stage stall requests, exceptions, interrupts and mret.
- Runs a trap/return FSM that redirects fetch to the trap vector (direct or vectored mtvec) or to mepc, and emits CSR save strobes.
- Sits beside the datapath; drives the fetch PC mux and every pipeline register's enable/clear.

Parameters:
- NSTAGE, 5, number of pipeline stages (>=3).
- XLEN, 32, address width.
- BR_STAGE, 2, stage index that resolves branch/jump; stages 0..BR_STAGE-1 are flushed on redirect.
- IRQ_W, 5, width of interrupt id.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- stall_req  in  NSTAGE  per-stage hold request (e.g. LSU busy in M).
- branch_taken, jump_taken  in  1  redirect resolved in BR_STAGE.
- branch_target_addr, jump_target_addr  in  XLEN  redirect targets.
- fence  in  1  fence.i in decode; refetch.
- pc_if  in  XLEN  current fetch PC.
- exc_taken_wb  in  1  synchronous exception at W.
- exc_cause_wb  in  6  exception cause.
- exc_pc_wb  in  XLEN  PC of excepting instruction.
- mret_wb  in  1  mret retiring at W.
- irq_pending  in  1  enabled interrupt pending (mstatus.MIE & mie & mip, gated by CSR unit).
- irq_id  in  IRQ_W  interrupt number.
- mtvec  in  XLEN  [1:0]=mode (0 direct, 1 vectored), [XLEN-1:2]=base.
- mepc  in  XLEN  return address.
- set_pc_valid  out  1  fetch redirect strobe.
- set_pc  out  XLEN  redirect address.
- flush  out  NSTAGE  per-stage clear (bubble insert).
- stall  out  NSTAGE  per-stage hold.
- csr_save  out  1  one-cycle strobe: write mepc/mcause/mtval.
- csr_cause  out  6  {interrupt bit, code}.
- csr_epc  out  XLEN  PC saved to mepc.
- csr_mret  out  1  strobe: restore mstatus.
- irq_taken_wb  out  1  interrupt accepted at W.

Behaviour:
- Reset: FSM=IDLE; all outputs 0; trap-target register 0.
- FSM states: IDLE, TRAP, RET.
- IDLE->TRAP on trap_take = exc_taken_wb | irq_take.
  - irq_take = irq_pending & ~exc_taken_wb & ~stall[NSTAGE-1] & ~mret_wb; exception wins over an interrupt in the same cycle.
  - Same cycle: flush = all ones; csr_save = 1.
  - csr_cause = exception ? {1'b0, exc_cause_wb[4:0]} : {1'b1, irq_id zero-extended}.
  - csr_epc = exc_pc_wb (the interrupted instruction's PC for an interrupt).
  - irq_taken_wb = irq_take.
  - Trap target latched: direct -> base<<2; vectored and interrupt -> (base<<2) + 4*irq_id; vectored and exception -> base<<2.
- IDLE->RET on mret_wb & ~exc_taken_wb: flush = all ones; csr_mret = 1; mepc latched.
- TRAP/RET -> IDLE unconditionally after one cycle.
  - This cycle: set_pc_valid = 1; set_pc = latched target; flush[0] = 1; stall = 0.
  - New trap inputs are ignored; the pipeline is empty.
- Stall (IDLE only): stall[i] = OR(stall_req[i..NSTAGE-1]), so back-pressure propagates toward F.
- Bubble: flush[i] = stall[i-1] & ~stall[i] for i>=1, inserting a bubble downstream of the held stage.
- Branch/jump in IDLE, with no trap_take and no mret_wb:
  - Accepted only if ~stall[BR_STAGE].
  - set_pc_valid = 1; set_pc = jump_target if jump_taken else branch_target (jump wins if both).
  - flush[0..BR_STAGE-1] = 1.
  - A redirect while BR_STAGE is stalled is dropped; the stage re-presents it next cycle.
- Fence in IDLE, with no branch/jump/trap and ~stall[1]: set_pc_valid = 1; set_pc = pc_if; flush[0] = 1.
- Priority: TRAP/RET redirect > trap_take/mret flush > branch/jump > fence > stall/bubble.
- Flush dominates stall in any stage where both are asserted; stall[i] is forced 0 whenever flush[i] = 1.
- set_pc is 0 when set_pc_valid = 0.
- Reset mid-TRAP returns to IDLE without a redirect.
- All outputs except the FSM/latched target are combinational from inputs and state; redirect latency after a trap is 1 cycle.

Decomposition:
- Package pipe_ctrl_pkg: FSM state enum; mtvec mode constants; cause-width localparam; helper function for the vectored target computation.
- One sub-module, pipe_stall_chain: computes the stall/bubble vectors from stall_req, generated over NSTAGE.

Test Plan:
- Reset, then stall_req=5'b01000 (M busy) -> stall=5'b01111, flush=5'b10000; release -> stall=0, flush=0.
- branch_taken, target 0x100, no stall -> set_pc_valid=1, set_pc=0x100, flush=5'b00011 same cycle; repeat with stall_req[2]=1 -> set_pc_valid=0.
- exc_taken_wb, cause 2, exc_pc_wb=0x80, mtvec=0x1000 -> cycle0: flush=5'b11111, csr_save=1, csr_cause=6'h02, csr_epc=0x80; cycle1: set_pc_valid=1, set_pc=0x1000.
- mtvec=0x1001, irq_pending, irq_id=7 -> irq_taken_wb=1, csr_cause=6'h27; next cycle set_pc=0x101C.
- exc_taken_wb with irq_pending and branch_taken in the same cycle -> exception only, no branch redirect, irq_taken_wb=0; mret_wb with mepc=0x200 -> csr_mret=1, next cycle set_pc=0x200.
- reset_n deasserted during TRAP cycle -> no set_pc_valid after release; fence with pc_if=0x40 -> set_pc=0x40, flush=5'b00001.
